// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX pipeline buffer: opcodes, writeback
// select, the registered EX bundle and source-register usage helpers.
package id_ex_stage_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_MEM       = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector;

  typedef struct packed {
    logic                   valid;
    logic [6:0]             opcode;
    logic [REG_W-1:0]       rs1;
    logic [REG_W-1:0]       rs2;
    logic [REG_W-1:0]       rd;
    logic [XLEN-1:0]        rs1_data;
    logic [XLEN-1:0]        rs2_data;
    logic [XLEN-1:0]        imm;
    write_back_mux_selector wb_mux;
  } id_ex_bundle_t;

  // A bubble has rd=x0 and no writeback, so it can never be forwarded from.
  localparam id_ex_bundle_t BUBBLE = '{
    valid:    1'b0,
    opcode:   7'd0,
    rs1:      '0,
    rs2:      '0,
    rd:       '0,
    rs1_data: '0,
    rs2_data: '0,
    imm:      '0,
    wb_mux:   NO_WRITEBACK
  };

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPCODE_OP)    || (opc == OPCODE_OPIMM)  ||
           (opc == OPCODE_LOAD)  || (opc == OPCODE_STORE)  ||
           (opc == OPCODE_BRANCH)|| (opc == OPCODE_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPCODE_OP) || (opc == OPCODE_STORE) || (opc == OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  // Count register with synchronous reset/clear.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) count_q <= '0;
    else                    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline buffer with load-use hazard detection and bubble insertion.
//
// Handshake: id_valid_ip marks a real instruction in ID. When stall_op is
// high that instruction is NOT consumed; IF/ID must present it again next
// cycle while a bubble enters EX. hold_ip freezes this stage entirely and
// masks stall_op; flush_ip kills the instruction entering EX and also masks
// stall_op.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = id_ex_stage_pkg::XLEN,
  parameter int REG_W = id_ex_stage_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold_ip,
  input  logic                   flush_ip,
  input  logic                   id_valid_ip,
  input  logic [6:0]             id_instr_opcode_ip,
  input  logic [REG_W-1:0]       id_rs1_ip,
  input  logic [REG_W-1:0]       id_rs2_ip,
  input  logic [REG_W-1:0]       id_rd_ip,
  input  logic [XLEN-1:0]        id_rs1_data_ip,
  input  logic [XLEN-1:0]        id_rs2_data_ip,
  input  logic [XLEN-1:0]        id_imm_ip,
  input  write_back_mux_selector id_wb_mux_ip,
  output logic                   stall_op,
  output logic                   ex_valid_op,
  output logic [6:0]             ex_instr_opcode_op,
  output logic [REG_W-1:0]       ex_rs1_op,
  output logic [REG_W-1:0]       ex_rs2_op,
  output logic [REG_W-1:0]       ex_rd_op,
  output logic [XLEN-1:0]        ex_rs1_data_op,
  output logic [XLEN-1:0]        ex_rs2_data_op,
  output logic [XLEN-1:0]        ex_imm_op,
  output write_back_mux_selector ex_wb_mux_op,
  output logic [CNT_W-1:0]       stall_cnt_op,
  output logic [CNT_W-1:0]       flush_cnt_op
);

  id_ex_bundle_t ex_q, ex_d, id_b;
  logic          load_use;
  logic          inc_stall, inc_flush;

  // Pack the ID fields into the bundle that would be captured this cycle.
  always_comb begin
    id_b          = BUBBLE;
    id_b.valid    = 1'b1;
    id_b.opcode   = id_instr_opcode_ip;
    id_b.rs1      = id_rs1_ip;
    id_b.rs2      = id_rs2_ip;
    id_b.rd       = id_rd_ip;
    id_b.rs1_data = id_rs1_data_ip;
    id_b.rs2_data = id_rs2_data_ip;
    id_b.imm      = id_imm_ip;
    id_b.wb_mux   = id_wb_mux_ip;
  end

  // Load-use: the load in EX produces its data too late for the ID consumer.
  always_comb begin
    load_use = ex_q.valid && (ex_q.opcode == OPCODE_LOAD) && (ex_q.rd != '0) &&
               id_valid_ip &&
               ((uses_rs1(id_instr_opcode_ip) && (id_rs1_ip == ex_q.rd)) ||
                (uses_rs2(id_instr_opcode_ip) && (id_rs2_ip == ex_q.rd)));
  end

  assign stall_op  = load_use && !flush_ip && !hold_ip && !reset;
  assign inc_stall = load_use && !flush_ip && !hold_ip;
  assign inc_flush = flush_ip && !hold_ip;

  // Next EX contents in priority order: hold, flush, load-use, capture.
  always_comb begin
    ex_d = ex_q;
    if (hold_ip)          ex_d = ex_q;
    else if (flush_ip)    ex_d = BUBBLE;
    else if (load_use)    ex_d = BUBBLE;
    else if (id_valid_ip) ex_d = id_b;
    else                  ex_d = BUBBLE;
  end

  // EX register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= BUBBLE;
    else       ex_q <= ex_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (1'b0),
    .inc_i   (inc_stall),
    .count_o (stall_cnt_op)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (1'b0),
    .inc_i   (inc_flush),
    .count_o (flush_cnt_op)
  );

  assign ex_valid_op        = ex_q.valid;
  assign ex_instr_opcode_op = ex_q.opcode;
  assign ex_rs1_op          = ex_q.rs1;
  assign ex_rs2_op          = ex_q.rs2;
  assign ex_rd_op           = ex_q.rd;
  assign ex_rs1_data_op     = ex_q.rs1_data;
  assign ex_rs2_data_op     = ex_q.rs2_data;
  assign ex_imm_op          = ex_q.imm;
  assign ex_wb_mux_op       = ex_q.wb_mux;

endmodule
